// File: rtl/main_pkg.sv
// main_pkg: shared types and constants for the least-significant-zero finder.
//   state_t  : search FSM states
//   DATA_W   : operand / result width
//   CNT_W    : bit-index counter width (must hold DATA_W)
//   NO_ZERO  : result reported when the operand contains no zero bit
package main_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;

   localparam logic [CNT_W-1:0] NO_ZERO = CNT_W'(DATA_W);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/lsz_scan_dp.sv
// lsz_scan_dp: datapath of the least-significant-zero finder.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture sw into the shift register and clear the counter
//   shift_en  : shift one bit right (1 enters the MSB) and bump the counter
//   sw        : operand word
//   cnt       : index of the bit currently at shift[0]
//   done      : current bit is zero, or every bit has been examined
module lsz_scan_dp
   import main_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] sw,
   output logic [CNT_W-1:0]  cnt,
   output logic              done
);

   logic [DATA_W-1:0] shift_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         cnt     <= '0;
      end else if (load) begin
         shift_q <= sw;
         cnt     <= '0;
      end else if (shift_en) begin
         // Filling with ones keeps shifted-in bits from looking like a zero.
         shift_q <= {1'b1, shift_q[DATA_W-1:1]};
         cnt     <= cnt + 1'b1;
      end
   end

   // The counter stops at NO_ZERO because the FSM leaves SCAN once done rises.
   assign done = ~shift_q[0] | (cnt == NO_ZERO);

endmodule

// File: rtl/main.sv
// main: sequential least-significant-zero-bit finder.
//   clk, rst : clock, asynchronous active-high reset
//   SW       : operand word, captured at the start of each search
//   HEX      : index of the lowest zero bit of the captured operand
//              (DATA_W when none), zero-extended and held until the
//              next search completes
module main
   import main_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] SW,
   output logic [DATA_W-1:0] HEX
);

   state_t            state;
   logic [DATA_W-1:0] sw_cap;
   logic [CNT_W-1:0]  cnt;
   logic              done;
   logic              load;
   logic              shift_en;

   assign load     = (state == LOAD);
   assign shift_en = (state == SCAN) && !done;

   lsz_scan_dp u_dp (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift_en (shift_en),
      .sw       (SW),
      .cnt      (cnt),
      .done     (done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= LOAD;
         HEX    <= '0;
         sw_cap <= '0;
      end else begin
         case (state)
            LOAD: begin
               sw_cap <= SW;
               state  <= SCAN;
            end
            SCAN: begin
               if (done) begin
                  HEX   <= DATA_W'(cnt);
                  state <= DONE;
               end
            end
            DONE: begin
               // HEX keeps the previous result through the next search.
               if (SW != sw_cap) state <= LOAD;
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_main.sv
module tb_main;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] SW  = '0;
   logic [31:0] HEX;

   int nvec = 0;
   int nerr = 0;

   main dut (
      .clk (clk),
      .rst (rst),
      .SW  (SW),
      .HEX (HEX)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sw;
      logic [31:0] exp_hex;
      int          exp_edge;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Hold reset for 3 clocks with SW applied, release at a falling edge.
   task automatic reset_with(input logic [31:0] sw);
      SW  = sw;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_hex", HEX, 32'd0);
      rst = 1'b0;
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic edge_tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      vecs[0] = '{32'b10111011,      32'd2,  4};
      vecs[1] = '{32'b111000,        32'd0,  2};
      vecs[2] = '{32'b101111111111,  32'd10, 12};
      vecs[3] = '{32'h0000FFFF,      32'd16, 18};
      vecs[4] = '{32'hFFFFFFFF,      32'd32, 34};
      vecs[5] = '{32'h000000EF,      32'd4,  6};

      for (int v = 0; v < 6; v++) begin
         reset_with(vecs[v].sw);
         for (int e = 1; e <= 40; e++) begin
            edge_tick();
            if (e == vecs[v].exp_edge - 1)
               check($sformatf("v%0d_before_edge%0d", v, e), HEX, 32'd0);
            if (e == vecs[v].exp_edge)
               check($sformatf("v%0d_at_edge%0d", v, e), HEX, vecs[v].exp_hex);
         end
         check($sformatf("v%0d_hold", v), HEX, vecs[v].exp_hex);

         // All-ones result must stay put for a long time.
         if (v == 4) begin
            bad = 0;
            for (int c = 0; c < 1000; c++) begin
               edge_tick();
               if (HEX !== 32'd32) bad++;
            end
            check("allones_hold_1000_bad_cycles", bad, 0);
         end
      end

      // Restart from DONE (HEX=4, SW=EF): change SW to 7 -> HEX=3 five edges later.
      @(negedge clk);
      SW = 32'h7;
      edge_tick();            // edge that sees the change
      check("restart_seen_edge", HEX, 32'd4);
      for (int e = 1; e <= 5; e++) begin
         edge_tick();
         if (e < 5) check($sformatf("restart_old_edge%0d", e), HEX, 32'd4);
         else       check("restart_new_edge5", HEX, 32'd3);
      end
      repeat (5) edge_tick();
      check("restart_hold", HEX, 32'd3);

      // Restart toward FFFF, then abort mid-scan with an async reset.
      @(negedge clk);
      SW = 32'hFFFF;
      repeat (6) edge_tick();
      check("midscan_old_result", HEX, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("midscan_async_reset", HEX, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         edge_tick();
         if (e == 17) check("post_reset_edge17", HEX, 32'd0);
         if (e == 18) check("post_reset_edge18", HEX, 32'd16);
      end
      check("post_reset_hold", HEX, 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/main.md
# main

Least-significant-zero-bit finder: it samples the 32-bit switch word `SW` and reports on `HEX` the bit index of the lowest bit equal to 0. It is the top-level compute block between the board switch inputs and the hex/number display driver. The search is sequential, one bit per clock, and the result is held stable on `HEX` until a new search completes.

## Interface
- `DATA_W`, 32: data width of `SW`, `HEX` and the internal shift register.
- `CNT_W`, 6: width of the bit-index counter; must hold the value `DATA_W`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `SW`, input, 32: operand word, sampled at the start of each search.
- `HEX`, output, 32: result index (0..32), zero-extended.

One clock; reset is asynchronous and active-high (`clk`, `rst`).

## Operation
- FSM states: LOAD, SCAN, DONE.
- Reset, asynchronous: state=LOAD, `HEX`=0, shift register=0, counter=0, captured-operand register=0.
- LOAD (1 cycle):
  - shift register ← `SW`; captured register ← `SW`; counter ← 0.
  - Next state is SCAN.
- SCAN, one bit per cycle:
  - If shift[0]==0 or counter==`DATA_W`: `HEX` ← counter, zero-extended, and go to DONE.
  - Otherwise: shift ← shift>>1 with a 1 shifted into the MSB, counter ← counter+1.
- All-ones operand: the counter reaches 32, so `HEX`=32. This is the defined "no zero" result.
- DONE:
  - `HEX` holds its value.
  - If `SW` ≠ captured register, go to LOAD and start a new search. `HEX` keeps the old result until the new result is written.
  - Otherwise stay in DONE.
- `SW` changes during SCAN are ignored until DONE.
- Counter arithmetic is unsigned `CNT_W` bits and never wraps, because it stops at `DATA_W`.

## Timing
- Edge numbering: edge 1 is the first rising edge after `rst` deasserts. At edge 1 the FSM is in LOAD.
- A result index n is written to `HEX` at edge n+2.
- Worst case (all ones): `HEX`=32 is written at edge 34.
- `HEX` is registered. It changes only on the single SCAN→DONE edge, or on reset.
- Restart after an `SW` change in DONE:
  - DONE→LOAD on the first edge that sees the change.
  - The new result arrives n+2 edges after that.
- `rst` asserted mid-search aborts immediately. `HEX`=0, and a fresh search begins after release.

## Structure
- Shared package `main_pkg`:
  - state enum {LOAD, SCAN, DONE}
  - `DATA_W`, `CNT_W` constants
  - `NO_ZERO` = `DATA_W` result constant
- One natural sub-module, `lsz_scan_dp`, the datapath. It holds:
  - the shift register with load/shift enables
  - the counter with clear/increment
  - the `done` flag, which is shift[0]==0 or counter==`DATA_W`

  The FSM and the `HEX`/captured-operand registers stay in `main`.

## Test plan
- `SW`=32'b10111011, reset held 3 clocks, then run ≥40 clocks → `HEX`=2. Check that it is written at edge 4 after release.
- `SW`=32'b111000 → `HEX`=0, written at edge 2.
- `SW`=32'b101111111111 → `HEX`=10. `SW`=32'h0000FFFF → `HEX`=16. `SW`=32'hEF → `HEX`=4.
- `SW`=32'hFFFFFFFF → `HEX`=32 at edge 34, and it holds for 1000 clocks.
- In DONE with `HEX`=4 (`SW`=32'hEF), change `SW` to 32'h7:
  - `HEX` stays 4 until the new result.
  - The new result `HEX`=3 arrives 5 edges after the change is seen.
- Assert `rst` mid-SCAN with `SW`=32'hFFFF → `HEX`=0 immediately, without waiting for a clock edge. After release, `HEX`=16 at edge 18.
